// File: rtl/binadd_operand_entry.sv
// Operand-entry stage for the 2-bit adder: two bouncy push-buttons become registered operands A/B.
// Each button is synchronised, debounced and edge-detected; BTN_INC bumps the selected operand, BTN_SEL flips the selection.
module binadd_operand_entry #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int CNT_W           = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_inc,
    input  logic             btn_sel,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             sel_b,
    output logic             upd
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int INC = 0;
    localparam int SEL = 1;

    logic [1:0]       raw;
    logic [1:0]       s1;
    logic [1:0]       s2;
    logic [1:0]       db;
    logic [1:0]       db_next;
    logic [1:0]       p;
    logic [1:0]       p_q;
    logic [CNT_W-1:0] cnt [2];

    assign raw = {btn_sel, btn_inc};

    // A new level is accepted only after it has differed from db for DEBOUNCE_CYCLES clocks in a row.
    always_comb begin
        db_next = db;
        for (int i = 0; i < 2; i++) begin
            if (s2[i] != db[i] && cnt[i] == CNT_LAST) begin
                db_next[i] = s2[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= '0;
            s2  <= '0;
            db  <= '0;
            p   <= '0;
            p_q <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1  <= raw;
            s2  <= s1;
            db  <= db_next;
            p   <= db_next & ~db;
            // Press pulses are retimed once so the operand moves DEBOUNCE_CYCLES+3 edges after the first sample.
            p_q <= p;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A simultaneous select press toggles sel_b on the same edge, so the increment sees the old selection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
            sel_b <= 1'b0;
            upd   <= 1'b0;
        end else begin
            upd <= 1'b0;
            if (p_q[INC]) begin
                upd <= 1'b1;
                if (sel_b) begin
                    b_out <= b_out + WIDTH'(1);
                end else begin
                    a_out <= a_out + WIDTH'(1);
                end
            end
            if (p_q[SEL]) begin
                sel_b <= ~sel_b;
            end
        end
    end

endmodule
